// File: rtl/concat_mult_add_grad_pkg.sv
// Q-format constants and accumulator saturation helpers shared by the forward
// and backward gate pre-activation datapaths.
package concat_mult_add_grad_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int FRACT_WIDTH = 4;
    localparam int ACC_WIDTH   = 16;
    localparam int PROD_WIDTH  = 2 * DATA_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRACT_WIDTH);

    // A sum carried one bit wider than the accumulator overflowed when its top two bits differ.
    function automatic logic acc_ovf(input logic signed [ACC_WIDTH:0] v);
        return v[ACC_WIDTH] ^ v[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] v);
        if (!acc_ovf(v)) begin
            return v[ACC_WIDTH-1:0];
        end else if (v[ACC_WIDTH]) begin
            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/concat_mult_add_grad_qmult_sat.sv
// Fixed-point multiplier slice: full-width product for stage-1 capture, and a
// floor shift plus saturation of the captured product for stage 2.
module qmult_sat #(
    parameter int IW = 8,
    parameter int FW = 4,
    parameter int OW = 8
) (
    input  logic signed [IW-1:0]   a,
    input  logic signed [IW-1:0]   b,
    output logic signed [2*IW-1:0] prod,
    input  logic signed [2*IW-1:0] prod_q,
    output logic signed [OW-1:0]   res,
    output logic                   sat
);

    // One guard bit beyond the wider of product and result so the limits compare as signed.
    localparam int EW = ((2 * IW > OW) ? 2 * IW : OW) + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [2*IW-1:0] shifted;
    logic signed [EW-1:0]   ext;

    assign prod    = a * b;
    assign shifted = prod_q >>> FW;
    assign ext     = {{(EW-2*IW){shifted[2*IW-1]}}, shifted};

    always_comb begin
        res = ext[OW-1:0];
        sat = 1'b0;
        if (ext > MAX_V) begin
            res = MAX_V[OW-1:0];
            sat = 1'b1;
        end else if (ext < MIN_V) begin
            res = MIN_V[OW-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/concat_mult_add_grad.sv
// Backward pass of out = W0*X + W1*h_in + b: input gradients plus running
// weight/bias gradient accumulators, in a two-stage valid/ready pipeline.
module concat_mult_add_grad
    import concat_mult_add_grad_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] delta,
    input  logic signed [DATA_WIDTH-1:0] X,
    input  logic signed [DATA_WIDTH-1:0] h_in,
    input  logic signed [DATA_WIDTH-1:0] W0,
    input  logic signed [DATA_WIDTH-1:0] W1,
    input  logic                         clear_acc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] dX,
    output logic signed [DATA_WIDTH-1:0] dh,
    output logic signed [ACC_WIDTH-1:0]  dW0,
    output logic signed [ACC_WIDTH-1:0]  dW1,
    output logic signed [ACC_WIDTH-1:0]  db,
    output logic                         sat_flag
);

    logic v1, v2, adv2, accept;

    logic signed [PROD_WIDTH-1:0] prod_w0, prod_w1, prod_x, prod_h;
    logic signed [PROD_WIDTH-1:0] p_w0, p_w1, p_x, p_h;
    logic signed [DATA_WIDTH-1:0] d1;

    logic signed [DATA_WIDTH-1:0] res_dx, res_dh;
    logic signed [ACC_WIDTH-1:0]  term_w0, term_w1, term_b;
    logic sat_dx, sat_dh, sat_w0, sat_w1;

    logic signed [ACC_WIDTH-1:0] base_w0, base_w1, base_b;
    logic signed [ACC_WIDTH:0]   sum_w0, sum_w1, sum_b;
    logic                        any_sat;

    // Stage 2 moves whenever it is empty or its result is being taken; stage 1 refills in the same cycle.
    assign adv2      = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | adv2;
    assign accept    = in_valid & in_ready;
    assign out_valid = v2;

    qmult_sat #(.IW(DATA_WIDTH), .FW(FRACT_WIDTH), .OW(DATA_WIDTH)) u_dx (
        .a(W0), .b(delta), .prod(prod_w0), .prod_q(p_w0), .res(res_dx), .sat(sat_dx)
    );
    qmult_sat #(.IW(DATA_WIDTH), .FW(FRACT_WIDTH), .OW(DATA_WIDTH)) u_dh (
        .a(W1), .b(delta), .prod(prod_w1), .prod_q(p_w1), .res(res_dh), .sat(sat_dh)
    );
    qmult_sat #(.IW(DATA_WIDTH), .FW(FRACT_WIDTH), .OW(ACC_WIDTH)) u_gw0 (
        .a(X), .b(delta), .prod(prod_x), .prod_q(p_x), .res(term_w0), .sat(sat_w0)
    );
    qmult_sat #(.IW(DATA_WIDTH), .FW(FRACT_WIDTH), .OW(ACC_WIDTH)) u_gw1 (
        .a(h_in), .b(delta), .prod(prod_h), .prod_q(p_h), .res(term_w1), .sat(sat_w1)
    );

    assign term_b  = {{(ACC_WIDTH-DATA_WIDTH){d1[DATA_WIDTH-1]}}, d1};

    // clear_acc alongside an advancing sample makes that sample the first of a new sequence.
    assign base_w0 = clear_acc ? '0 : dW0;
    assign base_w1 = clear_acc ? '0 : dW1;
    assign base_b  = clear_acc ? '0 : db;

    assign sum_w0  = {base_w0[ACC_WIDTH-1], base_w0} + {term_w0[ACC_WIDTH-1], term_w0};
    assign sum_w1  = {base_w1[ACC_WIDTH-1], base_w1} + {term_w1[ACC_WIDTH-1], term_w1};
    assign sum_b   = {base_b[ACC_WIDTH-1], base_b} + {term_b[ACC_WIDTH-1], term_b};

    assign any_sat = sat_dx | sat_dh | sat_w0 | sat_w1
                   | acc_ovf(sum_w0) | acc_ovf(sum_w1) | acc_ovf(sum_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            p_w0     <= '0;
            p_w1     <= '0;
            p_x      <= '0;
            p_h      <= '0;
            d1       <= '0;
            dX       <= '0;
            dh       <= '0;
            dW0      <= '0;
            dW1      <= '0;
            db       <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (accept) begin
                p_w0 <= prod_w0;
                p_w1 <= prod_w1;
                p_x  <= prod_x;
                p_h  <= prod_h;
                d1   <= delta;
                v1   <= 1'b1;
            end else if (adv2) begin
                v1   <= 1'b0;
            end

            if (adv2) begin
                v2 <= 1'b1;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end

            if (adv2) begin
                dX       <= res_dx;
                dh       <= res_dh;
                dW0      <= sat_acc(sum_w0);
                dW1      <= sat_acc(sum_w1);
                db       <= sat_acc(sum_b);
                sat_flag <= (clear_acc ? 1'b0 : sat_flag) | any_sat;
            end else if (clear_acc) begin
                dW0      <= '0;
                dW1      <= '0;
                db       <= '0;
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_concat_mult_add_grad.sv
// Scoreboard bench for concat_mult_add_grad: directed samples push expected
// results into a queue, a negedge monitor pops and compares on each handshake.
module tb_concat_mult_add_grad;
    import concat_mult_add_grad_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, clear_acc = 1'b0;
    logic        out_valid, out_ready = 1'b1, sat_flag;
    logic [7:0]  delta = '0, X = '0, h_in = '0, W0 = '0, W1 = '0, dX, dh;
    logic [15:0] dW0, dW1, db;

    int tests = 0, fails = 0, pops = 0, pushes = 0;
    bit saw_block = 0;

    // {dX, dh, dW0, dW1, db, sat_flag}
    logic [64:0] exp_q[$];

    int m_w0 = 0, m_w1 = 0, m_b = 0;
    bit m_sat = 0;
    logic [7:0] m_dx = '0;

    always #5 clk = ~clk;

    concat_mult_add_grad dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .delta(delta), .X(X), .h_in(h_in), .W0(W0), .W1(W1), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready), .dX(dX), .dh(dh),
        .dW0(dW0), .dW1(dW1), .db(db), .sat_flag(sat_flag)
    );

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic push_expected(input logic [7:0] d, x, h, w0, w1, input bit clr);
        int sd, rdx, rdh, s0, s1, sb;
        bit s;
        sd  = int'($signed(d));
        rdx = (int'($signed(w0)) * sd) >>> FRACT_WIDTH;
        rdh = (int'($signed(w1)) * sd) >>> FRACT_WIDTH;
        if (clr) begin
            m_w0 = 0; m_w1 = 0; m_b = 0; m_sat = 0;
        end
        s0 = m_w0 + ((int'($signed(x)) * sd) >>> FRACT_WIDTH);
        s1 = m_w1 + ((int'($signed(h)) * sd) >>> FRACT_WIDTH);
        sb = m_b + sd;
        s  = m_sat;
        s |= (clampi(rdx, -128, 127) != rdx) || (clampi(rdh, -128, 127) != rdh);
        s |= (clampi(s0, -32768, 32767) != s0) || (clampi(s1, -32768, 32767) != s1);
        s |= (clampi(sb, -32768, 32767) != sb);
        m_w0  = clampi(s0, -32768, 32767);
        m_w1  = clampi(s1, -32768, 32767);
        m_b   = clampi(sb, -32768, 32767);
        m_sat = s;
        m_dx  = 8'(clampi(rdx, -128, 127));
        exp_q.push_back({m_dx, 8'(clampi(rdh, -128, 127)), 16'(m_w0), 16'(m_w1), 16'(m_b), m_sat});
        pushes++;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the sample.
    task automatic send(input logic [7:0] d, x, h, w0, w1, input bit clr);
        int guard = 0;
        delta = d; X = x; h_in = h; W0 = w0; W1 = w1;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            push_expected(d, x, h, w0, w1, clr);
            if (clr) begin
                clear_acc = 1'b1;
                @(posedge clk);
                #1;
                clear_acc = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("drain", 65'(exp_q.size()), 65'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && in_valid && !in_ready) saw_block = 1;
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got dX=%h dW0=%h with empty queue, expected none", dX, dW0);
            end else begin
                logic [64:0] want;
                want = exp_q.pop_front();
                pops++;
                if ({dX, dh, dW0, dW1, db, sat_flag} !== want) begin
                    fails++;
                    $display("FAIL out%0d: got dX=%h dh=%h dW0=%h dW1=%h db=%h sat=%b, expected dX=%h dh=%h dW0=%h dW1=%h db=%h sat=%b",
                             pops, dX, dh, dW0, dW1, db, sat_flag,
                             want[64:57], want[56:49], want[48:33], want[32:17], want[16:1], want[0]);
                end
            end
        end
    end

    logic [64:0] held;
    bit held_ok = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_ok = 0;
        end else if (out_valid && !out_ready) begin
            if (held_ok) check("hold_stable", {dX, dh, dW0, dW1, db, sat_flag}, held);
            held    = {dX, dh, dW0, dW1, db, sat_flag};
            held_ok = 1;
        end else begin
            held_ok = 0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        check("reset_outputs", {dX, dh, dW0, dW1, db, sat_flag}, 65'd0);
        check("reset_out_valid", 65'(out_valid), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 65'(in_ready), 65'd1);
        @(posedge clk); #1;

        // 1.0 * weights, new sequence
        send(ONE, 8'h10, 8'h00, 8'h20, 8'h08, 1'b1);
        wait_idle();
        check("t1_dw0_hand", 65'(dW0), 65'h0010);

        // negative delta, latency, negative floor
        @(posedge clk); #1;
        send(8'hF0, 8'h00, 8'h00, 8'h10, 8'h18, 1'b0);
        @(negedge clk);
        check("latency_cycle1", 65'(out_valid), 65'd0);
        @(negedge clk);
        check("latency_cycle2", 65'(out_valid), 65'd1);
        check("t2_dh_hand", 65'(dh), 65'hE8);
        @(posedge clk); #1;
        send(8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
        wait_idle();
        check("t2_floor_hand", 65'(dX), 65'hFF);

        // dX clamps at both rails
        @(posedge clk); #1;
        send(8'h7F, 8'h00, 8'h00, 8'h7F, 8'h00, 1'b0);
        send(8'h7F, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);
        wait_idle();
        check("t3_dx_neg_hand", {57'd0, dX}, 65'h80);
        check("t3_sat_hand", 65'(sat_flag), 65'd1);

        // accumulation restarted by clear_acc, then clear_acc alone
        @(posedge clk); #1;
        send(8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1);
        send(8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
        send(8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_idle();
        check("t4_dw0_hand", 65'(dW0), 65'h0018);
        @(posedge clk); #1;
        clear_acc = 1'b1;
        @(posedge clk); #1;
        clear_acc = 1'b0;
        m_w0 = 0; m_w1 = 0; m_b = 0; m_sat = 0;
        check("clear_alone_acc", {dW0, dW1, db, sat_flag}, 65'd0);
        check("clear_alone_dx", 65'(dX), 65'(m_dx));

        // accumulator rails at +max, then an opposite term moves it off
        @(posedge clk); #1;
        send(8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 33; i++) send(8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_idle();
        check("acc_rail_hand", 65'(dW0), 65'h7FFF);
        @(posedge clk); #1;
        send(8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_idle();
        check("acc_off_rail_hand", 65'(dW0), 65'(16'd31751));

        // back-to-back stream with a 4-cycle stall
        saw_block = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'(8'h10 + i), 8'(i), 8'(8'hF8 + i), 8'(8'h03 * i), 8'(8'h40 - i), 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_idle();
        check("stream_backpressure", 65'(saw_block), 65'd1);
        check("stream_count", 65'(pops), 65'(pushes));

        // reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 1'b0);
        send(8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 1'b0);
        check("full_pipe", {63'd0, out_valid, in_ready}, 65'b10);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {dX, dh, dW0, dW1, db, sat_flag}, 65'd0);
        check("midrst_valid", 65'(out_valid), 65'd0);
        pushes = pushes - exp_q.size();
        exp_q.delete();
        m_w0 = 0; m_w1 = 0; m_b = 0; m_sat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'h10, 8'h20, 8'h10, 8'h10, 8'h10, 1'b0);
        wait_idle();
        check("post_reset_dw0_hand", 65'(dW0), 65'h0020);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
